// File: rtl/ddr_alpha_unpack_if.sv
// AXI-Stream slave bundle carrying 256-bit DDR readback words into the alpha unpacker.
// Handshake: a word transfers on a rising edge where s_axis_tvalid && s_axis_tready are both high;
// the master holds tdata/tvalid stable until that edge, and tready never depends on tvalid.
interface ddr_alpha_unpack_if #(
  parameter int DATA_W = 256
) ();
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready
  );
endinterface

// File: rtl/ddr_alpha_unpack.sv
// Unpacks 256-bit DDR readback words into 4-bit symbols, LSB first, one per rd_en_4 strobe.
// Active/next word registers hide DDR latency so symbol output never gaps across word boundaries.
module ddr_alpha_unpack #(
  parameter int DATA_W = 256,
  parameter int SYM_W  = 4
) (
  input  logic                clk200_i,
  input  logic                ddr_unpack_rst,
  input  logic                sr_unpack_enable_i,
  input  logic                sr_clear_i,
  input  logic                rd_en_4,
  ddr_alpha_unpack_if.slave   s_axis,
  output logic [SYM_W-1:0]    sym_o,
  output logic                sym_valid_o,
  output logic                underflow_o,
  output logic [47:0]         sym_count_o,
  output logic [31:0]         word_count_o,
  output logic [1:0]          state_o
);

  localparam int NSYM  = DATA_W / SYM_W;
  localparam int IDX_W = $clog2(NSYM);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] active_word;
  logic [DATA_W-1:0] next_word;
  logic              act_full;
  logic              next_full;
  logic [IDX_W-1:0]  idx;

  logic accept;
  logic running;
  logic strobe;
  logic emit;
  logic starve;
  logic last_sym;
  logic act_free;

  // tready comes from registered state only, so no tvalid-to-tready path exists.
  assign s_axis.s_axis_tready = (state == ST_FILL) || ((state == ST_RUN) && !next_full);

  assign accept   = s_axis.s_axis_tvalid && s_axis.s_axis_tready;
  assign running  = sr_unpack_enable_i && (state != ST_IDLE);
  assign strobe   = rd_en_4 && running;
  assign emit     = strobe && act_full;
  assign starve   = strobe && !act_full;
  assign last_sym = emit && (idx == IDX_W'(NSYM - 1));
  // Active can take a word this edge if it is empty or its final symbol is leaving now.
  assign act_free = !act_full || last_sym;

  assign state_o = state;

  always_ff @(posedge clk200_i or posedge ddr_unpack_rst) begin
    if (ddr_unpack_rst) begin
      state       <= ST_IDLE;
      active_word <= '0;
      next_word   <= '0;
      act_full    <= 1'b0;
      next_full   <= 1'b0;
      idx         <= '0;
      sym_o       <= '0;
      sym_valid_o <= 1'b0;
    end else begin
      sym_valid_o <= 1'b0;
      if (!sr_unpack_enable_i) begin
        state     <= ST_IDLE;
        act_full  <= 1'b0;
        next_full <= 1'b0;
        idx       <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_FILL;
          ST_FILL: if (accept) state <= ST_RUN;
          ST_RUN:  state <= ST_RUN;
          default: state <= ST_IDLE;
        endcase

        if (emit) begin
          sym_o       <= active_word[SYM_W-1:0];
          sym_valid_o <= 1'b1;
          active_word <= active_word >> SYM_W;
          idx         <= idx + 1'b1;
        end

        // Refill: a pending next word always moves up first; a new word lands behind it.
        if (act_free) begin
          if (next_full) begin
            active_word <= next_word;
            idx         <= '0;
            act_full    <= 1'b1;
            next_full   <= accept;
            if (accept) next_word <= s_axis.s_axis_tdata;
          end else if (accept) begin
            active_word <= s_axis.s_axis_tdata;
            idx         <= '0;
            act_full    <= 1'b1;
          end else begin
            act_full <= 1'b0;
          end
        end else if (accept) begin
          next_word <= s_axis.s_axis_tdata;
          next_full <= 1'b1;
        end
      end
    end
  end

  // Statistics survive disable; only reset or sr_clear_i zero them.
  always_ff @(posedge clk200_i or posedge ddr_unpack_rst) begin
    if (ddr_unpack_rst) begin
      underflow_o  <= 1'b0;
      sym_count_o  <= '0;
      word_count_o <= '0;
    end else if (sr_clear_i) begin
      underflow_o  <= 1'b0;
      sym_count_o  <= '0;
      word_count_o <= '0;
    end else begin
      if (starve) underflow_o  <= 1'b1;
      if (emit)   sym_count_o  <= sym_count_o + 48'd1;
      if (accept) word_count_o <= word_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_ddr_alpha_unpack.sv
// Bench for ddr_alpha_unpack: symbol-queue scoreboard fed by accepted words, drained by strobes.
`timescale 1ns/100ps
module tb_ddr_alpha_unpack;
  localparam int DATA_W = 256;
  localparam int SYM_W  = 4;
  localparam int NSYM   = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic clr;
  logic rd;
  always #5 clk = ~clk;

  ddr_alpha_unpack_if #(.DATA_W(DATA_W)) axis ();

  logic [SYM_W-1:0] sym_o;
  logic             sym_valid_o;
  logic             underflow_o;
  logic [47:0]      sym_count_o;
  logic [31:0]      word_count_o;
  logic [1:0]       state_o;

  ddr_alpha_unpack #(.DATA_W(DATA_W), .SYM_W(SYM_W)) dut (
    .clk200_i           (clk),
    .ddr_unpack_rst     (rst),
    .sr_unpack_enable_i (en),
    .sr_clear_i         (clr),
    .rd_en_4            (rd),
    .s_axis             (axis),
    .sym_o              (sym_o),
    .sym_valid_o        (sym_valid_o),
    .underflow_o        (underflow_o),
    .sym_count_o        (sym_count_o),
    .word_count_o       (word_count_o),
    .state_o            (state_o)
  );

  // ---------------- scoreboard / model ----------------
  logic [SYM_W-1:0] exp_q[$];
  int               ms;
  logic [47:0]      m_sym_cnt;
  logic [31:0]      m_word_cnt;
  logic             m_uf;
  logic [SYM_W-1:0] m_sym;
  logic             m_valid;
  logic             last_hs;
  int               n_vec = 0;
  int               n_err = 0;

  logic [DATA_W-1:0] w [0:7];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ms         = 0;
    m_sym_cnt  = '0;
    m_word_cnt = '0;
    m_uf       = 1'b0;
    m_sym      = '0;
    m_valid    = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One clock: predict at the falling edge, check #1 after the rising edge.
  task automatic tick();
    logic              exp_rdy;
    logic              uf_evt;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    exp_rdy = (ms == 1) || (ms == 2 && exp_q.size() <= NSYM);
    check("tready", {63'd0, axis.s_axis_tready}, {63'd0, exp_rdy});
    last_hs = axis.s_axis_tvalid && axis.s_axis_tready;
    d       = axis.s_axis_tdata;
    m_valid = 1'b0;
    uf_evt  = 1'b0;
    if (en && ms != 0 && rd) begin
      if (exp_q.size() > 0) begin
        m_sym   = exp_q.pop_front();
        m_valid = 1'b1;
      end else begin
        uf_evt = 1'b1;
      end
    end
    if (en && last_hs)
      for (int k = 0; k < NSYM; k++) exp_q.push_back(d[SYM_W*k +: SYM_W]);
    if (!en) exp_q.delete();
    if (clr) begin
      m_sym_cnt  = '0;
      m_word_cnt = '0;
      m_uf       = 1'b0;
    end else begin
      if (m_valid) m_sym_cnt  = m_sym_cnt + 48'd1;
      if (last_hs) m_word_cnt = m_word_cnt + 32'd1;
      if (uf_evt)  m_uf       = 1'b1;
    end
    if (!en) ms = 0;
    else if (ms == 0) ms = 1;
    else if (ms == 1 && last_hs) ms = 2;
    @(posedge clk);
    #1;
    check("sym_valid", {63'd0, sym_valid_o}, {63'd0, m_valid});
    check("sym", {60'd0, sym_o}, {60'd0, m_sym});
    check("underflow", {63'd0, underflow_o}, {63'd0, m_uf});
    check("sym_count", {16'd0, sym_count_o}, {16'd0, m_sym_cnt});
    check("word_count", {32'd0, word_count_o}, {32'd0, m_word_cnt});
    check("state", {62'd0, state_o}, ms[63:0]);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] word);
    bit got = 0;
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tdata  = word;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = last_hs;
    end
    check("hs_timeout", {63'd0, got}, 64'd1);
    axis.s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, {63'd0, axis.s_axis_tready}, 64'd0);
    check({tag, "_sym"}, {60'd0, sym_o}, 64'd0);
    check({tag, "_valid"}, {63'd0, sym_valid_o}, 64'd0);
    check({tag, "_uf"}, {63'd0, underflow_o}, 64'd0);
    check({tag, "_symcnt"}, {16'd0, sym_count_o}, 64'd0);
    check({tag, "_wordcnt"}, {32'd0, word_count_o}, 64'd0);
    check({tag, "_state"}, {62'd0, state_o}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] pat;
    int          widx;
    pat = 64'hFEDCBA9876543210;
    w[0] = {4{pat}};
    for (int i = 1; i < 8; i++) w[i] = rand_word();

    rst = 1'b1; en = 1'b0; clr = 1'b0; rd = 1'b0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata  = '0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Order: symbols 0..F four times, strobes 5 cycles apart.
    en = 1'b1;
    tick();
    send_word(w[0]);
    for (int i = 0; i < NSYM; i++) begin
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("t1_order", {60'd0, sym_o}, i % 16);
      idle(4);
    end
    check("t1_symcnt", {16'd0, sym_count_o}, 64'd64);
    check("t1_wordcnt", {32'd0, word_count_o}, 64'd1);

    // Back-to-back: three words, strobe every cycle, no gaps.
    clr = 1'b1; tick(); clr = 1'b0;
    widx = 0;
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tdata  = w[1];
    for (int i = 0; i <= 3 * NSYM; i++) begin
      rd = (i > 0);
      tick();
      if (i > 0) check("t2_contig", {63'd0, sym_valid_o}, 64'd1);
      if (last_hs) begin
        widx++;
        if (widx < 3) axis.s_axis_tdata = w[1 + widx];
        else axis.s_axis_tvalid = 1'b0;
      end
    end
    rd = 1'b0;
    check("t2_symcnt", {16'd0, sym_count_o}, 64'd192);
    check("t2_wordcnt", {32'd0, word_count_o}, 64'd3);
    check("t2_uf", {63'd0, underflow_o}, 64'd0);

    // Underflow: strobe with no data, then a word; flag sticks until clear.
    en = 1'b0; tick();
    en = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    rd = 1'b1; tick(); rd = 1'b0;
    check("t3_nosym", {63'd0, sym_valid_o}, 64'd0);
    check("t3_uf", {63'd0, underflow_o}, 64'd1);
    send_word(w[4]);
    rd = 1'b1; tick(); rd = 1'b0;
    check("t3_sym0", {60'd0, sym_o}, {60'd0, w[4][3:0]});
    check("t3_uf_sticky", {63'd0, underflow_o}, 64'd1);

    // Boundary refill: accept and consume symbol 63 on the same edge.
    rd = 1'b1;
    idle(62);
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tdata  = w[5];
    tick();
    axis.s_axis_tvalid = 1'b0;
    check("t4_hs", {63'd0, last_hs}, 64'd1);
    check("t4_sym63", {60'd0, sym_o}, {60'd0, w[4][255:252]});
    tick();
    rd = 1'b0;
    check("t4_newsym0", {60'd0, sym_o}, {60'd0, w[5][3:0]});
    check("t4_valid", {63'd0, sym_valid_o}, 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t3_uf_cleared", {63'd0, underflow_o}, 64'd0);

    // Disable mid-word: old word discarded, count continues.
    rd = 1'b1; idle(10); rd = 1'b0;
    check("t5_cnt10", {16'd0, sym_count_o}, 64'd10);
    en = 1'b0; tick();
    en = 1'b1; tick();
    send_word(w[6]);
    rd = 1'b1; tick(); rd = 1'b0;
    check("t5_newsym0", {60'd0, sym_o}, {60'd0, w[6][3:0]});
    check("t5_cnt11", {16'd0, sym_count_o}, 64'd11);

    // Async reset between edges while running.
    rd = 1'b1; idle(3); rd = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("areset");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    send_word(w[7]);
    rd = 1'b1; idle(2); rd = 1'b0;
    check("t6_sym1", {60'd0, sym_o}, {60'd0, w[7][7:4]});
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
